sel_encode18_5_seq: RTL and testbench

- Reverse direction of the 5-to-18 element-selector decoder in the DAC digital path.
- Accepts an 18-bit element-select mask and serialises it into a stream of 5-bit element addresses, one per cycle.
- Feeding each emitted address into the 5-to-18 decoder lights exactly one element of the original mask.
- Scan order is circular from a persistent rotation pointer, giving data-weighted-averaging element rotation for DAC mismatch shaping.

---
 rtl/sel_dac_pkg.sv | 19 +
 rtl/sel_rr_find18.sv | 34 +++
 rtl/sel_encode18_5_seq.sv | 83 ++++++++
 tb/tb_sel_encode18_5_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sel_dac_pkg.sv
// Shared constants, FSM state type and modular pointer helper for the
// DAC element-select encoder path.
package sel_dac_pkg;

   localparam int N_ELEM = 18;
   localparam int AW     = 5;

   typedef enum logic {
      IDLE,
      EMIT
   } state_t;

   // Increment an element index modulo N_ELEM (17 wraps to 0).
   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
      if (a == AW'(N_ELEM - 1)) return '0;
      return a + 1'b1;
   endfunction

endpackage

// File: rtl/sel_rr_find18.sv
// Circular priority finder: first set bit of pending at or above ptr.
// Ports: pending/ptr in; addr, found (any bit set), single (one bit set) out.
module sel_rr_find18
   import sel_dac_pkg::*;
(
   input  logic [N_ELEM-1:0] pending,
   input  logic [AW-1:0]     ptr,
   output logic [AW-1:0]     addr,
   output logic              found,
   output logic              single
);

   localparam logic [AW:0] NE = (AW+1)'(N_ELEM);

   logic [2*N_ELEM-1:0] dbl;
   logic [AW-1:0]       idx;
   logic [AW:0]         sum;

   // Rotate right by ptr so that bit 0 of dbl is element ptr.
   assign dbl = {pending, pending} >> ptr;

   always_comb begin
      idx = '0;
      for (int j = N_ELEM - 1; j >= 0; j--) begin
         if (dbl[j]) idx = AW'(j);
      end
   end

   assign sum    = {1'b0, ptr} + {1'b0, idx};
   assign addr   = (sum >= NE) ? AW'(sum - NE) : sum[AW-1:0];
   assign found  = |pending;
   assign single = found && ((pending & (pending - 1'b1)) == '0);

endmodule

// File: rtl/sel_encode18_5_seq.sv
// Serialises an 18-bit element mask into 5-bit addresses, rotating scan start.
// Ports: in_valid/in_ready/in_mask, ptr_clr, out_valid/out_ready/out_addr/out_last, mask_cnt, zero_pulse, ptr.
module sel_encode18_5_seq
   import sel_dac_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_ELEM-1:0] in_mask,
   input  logic              ptr_clr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [AW-1:0]     out_addr,
   output logic              out_last,
   output logic [AW-1:0]     mask_cnt,
   output logic              zero_pulse,
   output logic [AW-1:0]     ptr
);

   state_t            state, state_nx;
   logic [N_ELEM-1:0] pending;
   logic [AW-1:0]     f_addr;
   logic              f_found;
   logic              f_single;
   logic [AW-1:0]     pcnt;
   logic              accept;
   logic              hs;

   sel_rr_find18 u_find (
      .pending (pending),
      .ptr     (ptr),
      .addr    (f_addr),
      .found   (f_found),
      .single  (f_single)
   );

   always_comb begin
      pcnt = '0;
      for (int i = 0; i < N_ELEM; i++) begin
         pcnt = pcnt + {{(AW-1){1'b0}}, in_mask[i]};
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == EMIT);
   assign out_addr  = out_valid ? f_addr : '0;
   assign out_last  = out_valid && f_found && f_single;
   assign accept    = in_valid && in_ready;
   assign hs        = out_valid && out_ready;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept && (in_mask != '0)) state_nx = EMIT;
         EMIT: if (hs && out_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pending    <= '0;
         ptr        <= '0;
         mask_cnt   <= '0;
         zero_pulse <= 1'b0;
      end else begin
         state      <= state_nx;
         zero_pulse <= accept && (in_mask == '0);
         if (accept) begin
            pending  <= in_mask;
            mask_cnt <= pcnt;
         end else if (hs) begin
            pending[f_addr] <= 1'b0;
         end
         // ptr_clr only matters in IDLE, where no handshake can occur.
         if (hs) ptr <= wrap_inc(f_addr);
         else if (in_ready && ptr_clr) ptr <= '0;
      end
   end

endmodule

// File: tb/tb_sel_encode18_5_seq.sv
// Self-checking bench for sel_encode18_5_seq: vector table plus scoreboard
// of expected beats, and a hand-written mid-EMIT reset sequence.
module tb_sel_encode18_5_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [17:0] in_mask = '0;
   logic        ptr_clr = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [4:0]  out_addr;
   logic        out_last;
   logic [4:0]  mask_cnt;
   logic        zero_pulse;
   logic [4:0]  ptr;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int addr;
      bit last;
   } beat_t;

   typedef struct {
      logic [17:0] mask;
      bit          clr;
      bit          stall;
      int          cnt;
      int          fptr;
   } vec_t;

   beat_t sb[$];
   vec_t  tbl[8];
   int    mptr = 0;

   bit       pv_stall = 1'b0;
   bit [4:0] paddr = '0;

   sel_encode18_5_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mask    (in_mask),
      .ptr_clr    (ptr_clr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_last   (out_last),
      .mask_cnt   (mask_cnt),
      .zero_pulse (zero_pulse),
      .ptr        (ptr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference scan: walk elements from the model pointer, one beat per set bit.
   task automatic model_push(input logic [17:0] mask);
      logic [17:0] m;
      int p;
      int i;
      beat_t b;
      m = mask;
      p = mptr;
      while (m != '0) begin
         i = 0;
         for (int k = 0; k < 18; k++) begin
            i = (p + k) % 18;
            if (m[i]) break;
         end
         b.addr = i;
         b.last = ($countones(m) == 1);
         sb.push_back(b);
         m[i] = 1'b0;
         p = (i + 1) % 18;
      end
      mptr = p;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_beat", out_addr, 99);
            end else begin
               beat_t e;
               e = sb.pop_front();
               chk("beat_addr", out_addr, e.addr);
               chk("beat_last", out_last, e.last);
            end
         end
         if (pv_stall && out_valid) chk("stall_hold", out_addr, paddr);
         pv_stall = out_valid && !out_ready;
         paddr = out_addr;
      end else begin
         pv_stall = 1'b0;
      end
   end

   task automatic run_mask(input vec_t v);
      int n;
      int k;
      k = $countones(v.mask);
      if (v.clr) mptr = 0;
      in_valid = 1'b1;
      in_mask  = v.mask;
      ptr_clr  = v.clr;
      model_push(v.mask);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_mask  = '0;
      chk("mask_cnt", mask_cnt, v.cnt);
      if (k == 0) begin
         chk("zero_pulse_hi", zero_pulse, 1);
         chk("zero_no_valid", out_valid, 0);
         chk("zero_in_ready", in_ready, 1);
         ptr_clr = 1'b0;
         @(posedge clk); #1;
         chk("zero_pulse_lo", zero_pulse, 0);
         chk("zero_no_valid2", out_valid, 0);
      end else begin
         chk("emit_in_ready", in_ready, 0);
         n = 0;
         out_ready = 1'b1;
         while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
            out_ready = v.stall ? (n % 2 == 0) : 1'b1;
         end
         chk("emit_cycles", n, v.stall ? 2 * k - 1 : k);
         chk("sb_drained", sb.size(), 0);
      end
      ptr_clr   = 1'b0;
      out_ready = 1'b1;
      chk("final_ptr", ptr, v.fptr);
      chk("mask_cnt_hold", mask_cnt, v.cnt);
   endtask

   initial begin
      tbl[0] = '{18'h00001, 1'b0, 1'b0, 1, 1};
      tbl[1] = '{18'h20005, 1'b0, 1'b0, 3, 1};
      tbl[2] = '{18'h00010, 1'b0, 1'b0, 1, 5};
      tbl[3] = '{18'h3FFFF, 1'b0, 1'b1, 18, 5};
      tbl[4] = '{18'h00000, 1'b0, 1'b0, 0, 5};
      tbl[5] = '{18'h00100, 1'b0, 1'b0, 1, 9};
      tbl[6] = '{18'h00300, 1'b1, 1'b0, 2, 10};
      tbl[7] = '{18'h20000, 1'b0, 1'b0, 1, 0};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_ptr", ptr, 0);
      chk("rst_mask_cnt", mask_cnt, 0);
      chk("rst_zero_pulse", zero_pulse, 0);

      for (int t = 0; t < 8; t++) begin
         run_mask(tbl[t]);
         @(posedge clk); #1;
      end

      // Reset mid-EMIT: 4-bit mask from ptr 0, abort after two beats.
      in_valid = 1'b1;
      in_mask  = 18'h0000F;
      model_push(18'h0000F);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_mask  = '0;
      chk("rmid_cnt", mask_cnt, 4);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rmid_out_valid", out_valid, 0);
      chk("rmid_out_last", out_last, 0);
      chk("rmid_ptr", ptr, 0);
      chk("rmid_mask_cnt", mask_cnt, 0);
      chk("rmid_beats_left", sb.size(), 2);
      sb.delete();
      mptr = 0;
      @(posedge clk); #1;
      chk("rmid_hold_valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rmid_in_ready", in_ready, 1);
      run_mask('{18'h00006, 1'b0, 1'b0, 2, 3});

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
